// File: rtl/mem_port_arbiter_pkg.sv
// Shared defines for the memory port arbiter:
// FSM state codes, requester ids and the latched request bundle.
package mem_port_arbiter_pkg;

  localparam int RESULT_MSB = 1;
  localparam int SRC_MSB    = 0;

  localparam logic [RESULT_MSB:0] ST_IDLE = 2'd0;
  localparam logic [RESULT_MSB:0] ST_REQ  = 2'd1;
  localparam logic [RESULT_MSB:0] ST_WAIT = 2'd2;

  localparam logic [SRC_MSB:0] SRC_M0 = 1'b0;
  localparam logic [SRC_MSB:0] SRC_M1 = 1'b1;

  typedef struct packed {
    logic [SRC_MSB:0] owner;
    logic             write;
    logic [63:0]      index;
    logic [63:0]      wdata;
    logic [63:0]      wmask;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input grant cell: round-robin on a tie when RR=1,
// otherwise requester 1 always wins a tie.
module rr_arb2 #(
  parameter bit RR = 1'b1
) (
  input  logic req0,
  input  logic req1,
  input  logic last1,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      (req0 && req1): begin
        if (RR) begin
          gnt0 = last1;
          gnt1 = !last1;
        end else begin
          gnt1 = 1'b1;
        end
      end
      (req0 && !req1): gnt0 = 1'b1;
      (!req0 && req1): gnt1 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (m0) and load/store (m1) requesters onto
// one DDR port with a single outstanding transaction.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter bit PRIO_RR = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [63:0] m0_req_index,
  output logic        m0_resp_done,
  output logic [63:0] m0_resp_data,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_write,
  input  logic [63:0] m1_req_index,
  input  logic [63:0] m1_req_wdata,
  input  logic [63:0] m1_req_wmask,
  output logic        m1_resp_done,
  output logic [63:0] m1_resp_data,
  output logic        ddr_index_valid,
  input  logic        ddr_index_ready,
  output logic [63:0] ddr_index,
  output logic [63:0] ddr_write_data,
  output logic [63:0] ddr_write_mask,
  output logic        ddr_write,
  input  logic        ddr_operation_done,
  input  logic [63:0] ddr_read_data
);

  logic [RESULT_MSB:0] state;
  mem_req_t            req_r;
  mem_req_t            req_in;
  logic                last_m1;
  logic                gnt0;
  logic                gnt1;
  logic                idle;
  logic                accept;
  logic                done_w;

  // ready must stay low while reset holds the block
  assign idle = (state == ST_IDLE) && reset_n;

  rr_arb2 #(
    .RR(PRIO_RR)
  ) u_arb (
    .req0 (m0_req_valid),
    .req1 (m1_req_valid),
    .last1(last_m1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign m0_req_ready = idle && gnt0;
  assign m1_req_ready = idle && gnt1;
  assign accept = m0_req_ready || m1_req_ready;

  always_comb begin
    req_in = '0;
    req_in.owner = SRC_M0;
    req_in.index = m0_req_index;
    if (gnt1) begin
      req_in.owner = SRC_M1;
      req_in.write = m1_req_write;
      req_in.index = m1_req_index;
      req_in.wdata = m1_req_wdata;
      req_in.wmask = m1_req_wmask;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      req_r   <= '0;
      last_m1 <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_REQ;
            req_r   <= req_in;
            last_m1 <= gnt1;
          end
        end
        ST_REQ: begin
          if (ddr_index_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ddr_operation_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ddr_index_valid = (state == ST_REQ);
  assign ddr_index       = req_r.index;
  assign ddr_write       = req_r.write;
  assign ddr_write_data  = req_r.wdata;
  assign ddr_write_mask  = req_r.wmask;

  assign done_w = (state == ST_WAIT) && ddr_operation_done;

  assign m0_resp_done = done_w && (req_r.owner == SRC_M0);
  assign m1_resp_done = done_w && (req_r.owner == SRC_M1);
  assign m0_resp_data = m0_resp_done ? ddr_read_data : '0;
  assign m1_resp_data = m1_resp_done ? ddr_read_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: transaction-level model of grants, DDR
// requests and completions, with a fixed-priority side instance.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req_valid, m0_req_ready, m0_resp_done;
  logic [63:0] m0_req_index, m0_resp_data;
  logic        m1_req_valid, m1_req_ready, m1_req_write;
  logic [63:0] m1_req_index, m1_req_wdata, m1_req_wmask;
  logic        m1_resp_done;
  logic [63:0] m1_resp_data;
  logic        ddr_index_valid, ddr_index_ready, ddr_write;
  logic [63:0] ddr_index, ddr_write_data, ddr_write_mask;
  logic        ddr_operation_done;
  logic [63:0] ddr_read_data;

  logic        f_m0_ready, f_m1_ready, f_m0_done, f_m1_done;
  logic        f_ddr_valid, f_ddr_write;
  logic [63:0] f_m0_data, f_m1_data;
  logic [63:0] f_ddr_index, f_ddr_wdata, f_ddr_wmask;

  always #5 clock = ~clock;

  mem_port_arbiter #(.PRIO_RR(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
    .m0_req_index(m0_req_index), .m0_resp_done(m0_resp_done),
    .m0_resp_data(m0_resp_data),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
    .m1_req_write(m1_req_write), .m1_req_index(m1_req_index),
    .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask),
    .m1_resp_done(m1_resp_done), .m1_resp_data(m1_resp_data),
    .ddr_index_valid(ddr_index_valid),
    .ddr_index_ready(ddr_index_ready),
    .ddr_index(ddr_index), .ddr_write_data(ddr_write_data),
    .ddr_write_mask(ddr_write_mask), .ddr_write(ddr_write),
    .ddr_operation_done(ddr_operation_done),
    .ddr_read_data(ddr_read_data)
  );

  mem_port_arbiter #(.PRIO_RR(1'b0)) dut_fp (
    .clock(clock), .reset_n(reset_n),
    .m0_req_valid(1'b1), .m0_req_ready(f_m0_ready),
    .m0_req_index(64'h100), .m0_resp_done(f_m0_done),
    .m0_resp_data(f_m0_data),
    .m1_req_valid(1'b1), .m1_req_ready(f_m1_ready),
    .m1_req_write(1'b0), .m1_req_index(64'h200),
    .m1_req_wdata(64'h0), .m1_req_wmask(64'h0),
    .m1_resp_done(f_m1_done), .m1_resp_data(f_m1_data),
    .ddr_index_valid(f_ddr_valid), .ddr_index_ready(1'b1),
    .ddr_index(f_ddr_index), .ddr_write_data(f_ddr_wdata),
    .ddr_write_mask(f_ddr_wmask), .ddr_write(f_ddr_write),
    .ddr_operation_done(1'b1), .ddr_read_data(64'h55)
  );

  typedef struct {
    bit          owner;
    bit          wr;
    logic [63:0] idx;
    logic [63:0] wd;
    logic [63:0] wm;
  } exp_req_t;

  typedef struct {
    bit          owner;
    logic [63:0] data;
  } exp_rsp_t;

  exp_req_t req_q[$];
  exp_rsp_t rsp_q[$];
  bit       gq[$];
  bit       f_gq[$];

  int checks = 0;
  int errors = 0;

  // model: one transaction in flight, tracked by busy/fired
  bit busy = 0, fired = 0, last1 = 1, own = 0;
  int lat_cnt = 0, stall_left = 0;
  int lat_knob = -1, stall_knob = -1;
  bit spur = 0, spur_all = 0, fix_data = 0;
  logic [63:0] data_val = 64'h0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  always @(negedge clock) begin
    exp_req_t    q;
    exp_rsp_t    r;
    bit          e0, e1, ed0, ed1;
    logic [63:0] ev0, ev1;
    if (!reset_n) begin
      chk("reset_ctl", {58'd0, m0_req_ready, m1_req_ready,
          m0_resp_done, m1_resp_done, ddr_index_valid, ddr_write},
          64'd0);
      chk("reset_data", ddr_index | ddr_write_data |
          ddr_write_mask | m0_resp_data | m1_resp_data, 64'd0);
      req_q.delete();
      rsp_q.delete();
      busy = 0;
      fired = 0;
      last1 = 1;
    end else begin
      e0 = !busy && m0_req_valid && (!m1_req_valid || last1);
      e1 = !busy && m1_req_valid && !e0;
      chk("grant", {62'd0, m0_req_ready, m1_req_ready},
          {62'd0, e0, e1});
      chk("ddr_valid", {63'd0, ddr_index_valid},
          {63'd0, busy && !fired});
      if (ddr_index_valid && req_q.size() > 0) begin
        q = req_q[0];
        chk("ddr_index", ddr_index, q.idx);
        chk("ddr_write", {63'd0, ddr_write}, {63'd0, q.wr});
        chk("ddr_mask", ddr_write_mask, q.wm);
        if (q.wr) chk("ddr_wdata", ddr_write_data, q.wd);
        if (ddr_index_ready) begin
          void'(req_q.pop_front());
          fired = 1;
          lat_cnt = (lat_knob < 0) ? $urandom_range(0, 3) : lat_knob;
        end
      end
      ed0 = 0; ed1 = 0; ev0 = '0; ev1 = '0;
      if (rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        if (r.owner) begin
          ed1 = 1; ev1 = r.data;
        end else begin
          ed0 = 1; ev0 = r.data;
        end
        busy = 0;
        fired = 0;
      end
      chk("resp_done", {62'd0, m0_resp_done, m1_resp_done},
          {62'd0, ed0, ed1});
      chk("m0_resp_data", m0_resp_data, ev0);
      chk("m1_resp_data", m1_resp_data, ev1);
      if (e0 || e1) begin
        if (e1)
          req_q.push_back('{1'b1, m1_req_write, m1_req_index,
                            m1_req_wdata, m1_req_wmask});
        else
          req_q.push_back('{1'b0, 1'b0, m0_req_index,
                            64'd0, 64'd0});
        last1 = e1;
        own = e1;
        busy = 1;
        gq.push_back(e1);
        stall_left = (stall_knob < 0) ? $urandom_range(0, 3)
                                      : stall_knob;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && (f_m0_ready || f_m1_ready))
      f_gq.push_back(f_m1_ready);
  end

  // DDR responder: drives ready/done just after each rising edge
  task automatic tick();
    @(posedge clock);
    #1;
    ddr_operation_done = 1'b0;
    ddr_read_data = 64'd0;
    if (busy && !fired) begin
      ddr_index_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
    end else begin
      ddr_index_ready = 1'($urandom_range(0, 1));
    end
    if (fired && reset_n) begin
      if (lat_cnt == 0) begin
        ddr_operation_done = 1'b1;
        ddr_read_data = fix_data ? data_val : {$urandom, $urandom};
        rsp_q.push_back('{own, ddr_read_data});
      end else begin
        lat_cnt--;
      end
    end else if (spur_all || (spur && $urandom_range(0, 5) == 0)) begin
      ddr_operation_done = 1'b1;
      ddr_read_data = {$urandom, $urandom};
    end
  endtask

  task automatic rand_req();
    m0_req_valid = ($urandom_range(0, 9) < 6);
    m0_req_index = {$urandom, $urandom};
    m1_req_valid = ($urandom_range(0, 9) < 6);
    m1_req_write = 1'($urandom_range(0, 1));
    m1_req_index = {$urandom, $urandom};
    m1_req_wdata = {$urandom, $urandom};
    m1_req_wmask = {$urandom, $urandom};
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout busy=%0d exp=0 after %0d cycles",
               busy, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    m0_req_valid = 0; m0_req_index = '0;
    m1_req_valid = 0; m1_req_write = 0; m1_req_index = '0;
    m1_req_wdata = '0; m1_req_wmask = '0;
    ddr_index_ready = 0; ddr_operation_done = 0;
    ddr_read_data = '0;
    m0_req_valid = 1; m1_req_valid = 1;
    repeat (3) tick();
    m0_req_valid = 0; m1_req_valid = 0;
    reset_n = 1;

    // m0 read of 0x10, done three cycles into WAIT
    lat_knob = 3; stall_knob = 0; fix_data = 1;
    data_val = 64'hDEAD;
    tick();
    m0_req_valid = 1; m0_req_index = 64'h10;
    tick();
    m0_req_valid = 0;
    wait_idle(20);

    // m1 store held off by ddr_index_ready for four cycles
    lat_knob = 1; stall_knob = 4; data_val = 64'h1234;
    tick();
    m1_req_valid = 1; m1_req_write = 1;
    m1_req_index = 64'h20; m1_req_wdata = 64'hFF00;
    m1_req_wmask = 64'hFF00;
    tick();
    m1_req_valid = 0; m1_req_write = 0;
    wait_idle(20);

    // stray done pulses while idle
    spur_all = 1;
    repeat (4) tick();
    spur_all = 0;

    // reset pulse while waiting on DDR
    lat_knob = 12; stall_knob = 0;
    tick();
    m0_req_valid = 1; m0_req_index = 64'h30;
    tick();
    m0_req_valid = 0;
    n = 0;
    while (!fired && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (!fired) begin
      errors++;
      $display("FAIL fire_timeout fired=%0d exp=1", fired);
    end
    tick();
    reset_n = 0;
    m0_req_valid = 1; m1_req_valid = 1;
    tick();
    tick();
    m0_req_valid = 0; m1_req_valid = 0;
    reset_n = 1;
    lat_knob = 2;
    tick();
    m1_req_valid = 1; m1_req_write = 0; m1_req_index = 64'h40;
    tick();
    m1_req_valid = 0;
    wait_idle(20);

    // both requesters held valid after reset: m0, m1, m0, m1
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    lat_knob = 0; stall_knob = 0; fix_data = 0;
    gq.delete();
    n = 0;
    while (gq.size() < 4 && n < 60) begin
      tick();
      m0_req_valid = 1; m1_req_valid = 1;
      m0_req_index = {$urandom, $urandom};
      m1_req_index = {$urandom, $urandom};
      n++;
    end
    tick();
    m0_req_valid = 0; m1_req_valid = 0;
    wait_idle(20);
    chk("rr_count", 64'(gq.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      chk("rr_order", {63'd0, gq[i]}, 64'(i % 2));

    // randomized traffic
    lat_knob = -1; stall_knob = -1; spur = 1;
    repeat (400) begin
      tick();
      rand_req();
    end
    tick();
    m0_req_valid = 0; m1_req_valid = 0;
    spur = 0;
    wait_idle(40);
    repeat (3) tick();

    // fixed-priority instance saw m1 win every tie
    chk("fp_count", 64'(f_gq.size() >= 4), 64'd1);
    foreach (f_gq[i]) chk("fp_grant", {63'd0, f_gq[i]}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
